// File: rtl/im_fetch_master_if.sv
// AXI4 read-channel bundle between the instruction-fetch master and the
// interconnect. Only the AR and R channels exist: the fetch path never writes.
interface im_fetch_master_if #(
    parameter int ID_W = 4
) ();
    logic [ID_W-1:0] ARID;
    logic [31:0]     ARADDR;
    logic [3:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;
    logic [ID_W-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/im_fetch_master.sv
// Instruction-fetch AXI4 read master (M0). One single-beat read per fetch
// request; the IF stage is stalled while the read is in flight.
// Optional feature macro: IM_FETCH_ERR_NOP_EN -- an error response on the final
// beat returns a NOP (addi x0,x0,0) instead of the read data.
module im_fetch_master #(
    parameter int ID_W      = 4,
    parameter int MASTER_ID = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IM_read_i,
    input  logic [31:0] IM_addr_i,
    input  logic        AXI_MEM_stall_i,
    output logic [31:0] IM_instruction_o,
    output logic        AXI_IF_stall_o,
    im_fetch_master_if.master axi
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rdata_sel;
    logic        arvalid;
    logic        rready;
    logic        if_stall;

    // RID is never needed (single outstanding read); RRESP is only consulted
    // when the error-to-NOP substitution is built in.
    logic unused_ok;
    assign unused_ok = &{1'b0, axi.RID, axi.RRESP};

    // State, latched address and fetched instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            araddr_q <= 32'h0;
            instr_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            instr_q  <= instr_d;
        end
    end

    // Select the word loaded on the final read beat.
    always_comb begin
        rdata_sel = axi.RDATA;
`ifdef IM_FETCH_ERR_NOP_EN
        if (axi.RRESP != 2'b00) begin
            rdata_sel = NOP_INSTR;
        end
`endif
    end

    // Next-state and output decode for the fetch FSM.
    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        instr_d  = instr_q;
        arvalid  = 1'b0;
        rready   = 1'b0;
        if_stall = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (IM_read_i) begin
                    // Stall in the request cycle itself so the PC does not move.
                    if_stall = 1'b1;
                    araddr_d = IM_addr_i;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                arvalid  = 1'b1;
                if_stall = 1'b1;
                if (axi.ARREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                rready   = 1'b1;
                if_stall = 1'b1;
                // Non-final beats are accepted and dropped.
                if (axi.RVALID && axi.RLAST) begin
                    instr_d = rdata_sel;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Hold the result while the data side is stalled.
                if (!AXI_MEM_stall_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign axi.ARID    = ID_W'(MASTER_ID);
    assign axi.ARADDR  = araddr_q;
    assign axi.ARLEN   = 4'd0;
    assign axi.ARSIZE  = 3'b010;
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = arvalid;
    assign axi.RREADY  = rready;

    assign IM_instruction_o = instr_q;
    assign AXI_IF_stall_o   = if_stall;

endmodule

// File: tb/tb_im_fetch_master.sv
// Self-checking bench for im_fetch_master: a behavioural AXI slave with
// random wait states, beats and responses, checked cycle by cycle against
// expectations derived from the fetch protocol (latency, address, result).
module tb_im_fetch_master;
    localparam int ID_W      = 4;
    localparam int MASTER_ID = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        IM_read;
    logic [31:0] IM_addr;
    logic        AXI_MEM_stall;
    logic [31:0] IM_instruction;
    logic        AXI_IF_stall;

    im_fetch_master_if #(.ID_W(ID_W)) axi_bus ();

    im_fetch_master #(.ID_W(ID_W), .MASTER_ID(MASTER_ID)) dut (
        .clk              (clk),
        .rst              (rst),
        .IM_read_i        (IM_read),
        .IM_addr_i        (IM_addr),
        .AXI_MEM_stall_i  (AXI_MEM_stall),
        .IM_instruction_o (IM_instruction),
        .AXI_IF_stall_o   (AXI_IF_stall),
        .axi              (axi_bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_instr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected instruction word for a completed read.
    function automatic logic [31:0] model_result(input logic [31:0] data, input logic [1:0] resp);
`ifdef IM_FETCH_ERR_NOP_EN
        if (resp != 2'b00) return 32'h0000_0013;
`endif
        return data;
    endfunction

    // One complete fetch, entered at a negedge with the DUT in IDLE.
    // Returns the cycle number of the AR handshake.
    task automatic do_fetch(input logic [31:0] addr, input int ar_wait, input int r_wait,
                            input int nonlast, input logic [31:0] data, input logic [1:0] resp,
                            input int hold, input bit keep_read, output int ar_cyc);
        int stall_seen = 0;
        IM_read = 1'b1;
        IM_addr = addr;
        #1;
        check_eq("req_stall", 32'(AXI_IF_stall), 32'd1);
        check_eq("req_arvalid", 32'(axi_bus.ARVALID), 32'd0);
        stall_seen += int'(AXI_IF_stall);
        @(negedge clk);
        // Address phase: request-side inputs wander but must be ignored.
        for (int i = 0; i <= ar_wait; i++) begin
            axi_bus.ARREADY = (i == ar_wait);
            IM_addr = (i == 0) ? 32'h0000_0200 : $urandom;
            IM_read = 1'($urandom);
            #1;
            check_eq("addr_arvalid", 32'(axi_bus.ARVALID), 32'd1);
            check_eq("addr_araddr", axi_bus.ARADDR, addr);
            check_eq("addr_rready", 32'(axi_bus.RREADY), 32'd0);
            check_eq("addr_instr", IM_instruction, exp_instr);
            if (i == ar_wait) begin
                check_eq("arlen", 32'(axi_bus.ARLEN), 32'd0);
                check_eq("arsize", 32'(axi_bus.ARSIZE), 32'd2);
                check_eq("arburst", 32'(axi_bus.ARBURST), 32'd1);
                check_eq("arid", 32'(axi_bus.ARID), 32'(MASTER_ID));
                ar_cyc = cyc;
            end
            stall_seen += int'(AXI_IF_stall);
            @(negedge clk);
        end
        axi_bus.ARREADY = 1'b0;
        // Data phase: optional wait, optional discarded beats, final beat.
        for (int i = 0; i <= r_wait + nonlast; i++) begin
            axi_bus.RVALID = (i >= r_wait);
            axi_bus.RLAST  = (i == r_wait + nonlast);
            axi_bus.RDATA  = axi_bus.RLAST ? data : $urandom;
            axi_bus.RRESP  = axi_bus.RLAST ? resp : 2'($urandom_range(0, 3));
            axi_bus.RID    = 4'($urandom);
            #1;
            check_eq("data_rready", 32'(axi_bus.RREADY), 32'd1);
            check_eq("data_arvalid", 32'(axi_bus.ARVALID), 32'd0);
            check_eq("data_instr", IM_instruction, exp_instr);
            stall_seen += int'(AXI_IF_stall);
            @(negedge clk);
        end
        axi_bus.RVALID = 1'b0;
        axi_bus.RLAST  = 1'b0;
        exp_instr = model_result(data, resp);
        // Result phase, optionally held by the data-side stall.
        for (int h = 0; h <= hold; h++) begin
            AXI_MEM_stall = (h < hold);
            IM_read = keep_read;
            #1;
            check_eq("done_stall", 32'(AXI_IF_stall), 32'd0);
            check_eq("done_instr", IM_instruction, exp_instr);
            check_eq("done_arvalid", 32'(axi_bus.ARVALID), 32'd0);
            check_eq("done_rready", 32'(axi_bus.RREADY), 32'd0);
            @(negedge clk);
        end
        AXI_MEM_stall = 1'b0;
        check_eq("stall_cycles", 32'(stall_seen), 32'(3 + ar_wait + r_wait + nonlast));
        $display("fetch addr=%h arw=%0d rw=%0d extra=%0d resp=%0d hold=%0d instr=%h",
                 addr, ar_wait, r_wait, nonlast, resp, hold, exp_instr);
    endtask

    initial begin
        int ar_c;
        int prev_ar;
        rst = 1'b1;
        IM_read = 1'b0;
        IM_addr = 32'h0;
        AXI_MEM_stall = 1'b0;
        axi_bus.ARREADY = 1'b0;
        axi_bus.RVALID = 1'b0;
        axi_bus.RLAST = 1'b0;
        axi_bus.RDATA = 32'h0;
        axi_bus.RRESP = 2'b00;
        axi_bus.RID = '0;
        exp_instr = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_stall", 32'(AXI_IF_stall), 32'd0);
        check_eq("rst_arvalid", 32'(axi_bus.ARVALID), 32'd0);
        check_eq("rst_rready", 32'(axi_bus.RREADY), 32'd0);
        check_eq("rst_instr", IM_instruction, 32'h0);
        check_eq("rst_araddr", axi_bus.ARADDR, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait fetch, wait states, MEM hold, error response.
        do_fetch(32'h0000_0100, 0, 0, 0, 32'h0010_0093, 2'b00, 0, 1'b0, ar_c);
        do_fetch(32'h0000_0040, 3, 2, 0, 32'h1234_5678, 2'b00, 0, 1'b0, ar_c);
        do_fetch(32'h0000_0044, 0, 0, 0, 32'h00A0_0113, 2'b00, 4, 1'b0, ar_c);
        do_fetch(32'h0000_0048, 1, 1, 1, 32'hDEAD_BEEF, 2'b10, 0, 1'b0, ar_c);

        // Reset while waiting for RVALID.
        IM_read = 1'b1;
        IM_addr = 32'h0000_0800;
        @(negedge clk);
        axi_bus.ARREADY = 1'b1;
        @(negedge clk);
        axi_bus.ARREADY = 1'b0;
        IM_read = 1'b0;
        #1;
        check_eq("mid_rready", 32'(axi_bus.RREADY), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_instr = 32'h0;
        check_eq("mrst_arvalid", 32'(axi_bus.ARVALID), 32'd0);
        check_eq("mrst_rready", 32'(axi_bus.RREADY), 32'd0);
        check_eq("mrst_instr", IM_instruction, 32'h0);
        check_eq("mrst_stall", 32'(AXI_IF_stall), 32'd0);
        check_eq("mrst_araddr", axi_bus.ARADDR, 32'h0);
        @(negedge clk);

        // Back-to-back with IM_read held high: handshakes 4 cycles apart.
        do_fetch(32'h0000_0000, 0, 0, 0, 32'h0000_1111, 2'b00, 0, 1'b1, ar_c);
        prev_ar = ar_c;
        do_fetch(32'h0000_0004, 0, 0, 0, 32'h0000_2222, 2'b00, 0, 1'b1, ar_c);
        check_eq("b2b_gap1", 32'(ar_c - prev_ar), 32'd4);
        prev_ar = ar_c;
        do_fetch(32'h0000_0008, 0, 0, 0, 32'h0000_3333, 2'b00, 0, 1'b1, ar_c);
        check_eq("b2b_gap2", 32'(ar_c - prev_ar), 32'd4);

        // Randomized fetches.
        for (int n = 0; n < 40; n++) begin
            logic [1:0] resp;
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_fetch($urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), $urandom, resp, int'($urandom_range(0, 3)),
                     1'($urandom), ar_c);
        end

        IM_read = 1'b0;
        #1;
        check_eq("end_stall", 32'(AXI_IF_stall), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
